// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU in the EX stage.
// Operands are latched on an accepted start, and one quotient bit is
// resolved per clock. The result is sign-corrected and registered on the
// completing edge. busy drives the pipeline stall, and done pulses for one
// cycle when quotient/remainder become valid.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cancel,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    counter;

    // Partial remainder, and the dividend/quotient shift register:
    // dividend bits leave at the top while quotient bits enter at the bottom.
    logic [WIDTH-1:0] rem_acc;
    logic [WIDTH-1:0] quo_acc;
    logic [WIDTH-1:0] div_mag;
    logic [WIDTH-1:0] dividend_raw;
    logic             neg_q;
    logic             neg_r;
    logic             div_zero;

    logic             accept;
    logic             last_iter;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;

    // A new operation is accepted only when not iterating, and cancel always wins.
    assign accept    = start && !cancel && (state == IDLE || state == DONE);
    assign last_iter = (counter == CW'(WIDTH - 1));
    assign busy      = (state == BUSY);
    assign done      = (state == DONE);

    // Operand magnitudes; unsigned operands pass through untouched.
    assign a_mag = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign b_mag = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

    // One restoring step: shift in the next dividend bit, then try the subtraction.
    always_comb begin
        shifted  = {rem_acc, quo_acc[WIDTH-1]};
        diff     = shifted - {1'b0, div_mag};
        rem_step = shifted[WIDTH-1:0];
        quo_step = {quo_acc[WIDTH-2:0], 1'b0};
        if (!diff[WIDTH]) begin
            rem_step = diff[WIDTH-1:0];
            quo_step = {quo_acc[WIDTH-2:0], 1'b1};
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: cancel aborts BUSY/DONE, and DONE may chain straight into BUSY.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) state_next = BUSY;
            end
            BUSY: begin
                if (cancel)         state_next = IDLE;
                else if (last_iter) state_next = DONE;
            end
            DONE: begin
                if (accept) state_next = BUSY;
                else        state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, iterate in BUSY, and write the result on the last step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter      <= '0;
            rem_acc      <= '0;
            quo_acc      <= '0;
            div_mag      <= '0;
            dividend_raw <= '0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            div_zero     <= 1'b0;
            quotient     <= '0;
            remainder    <= '0;
        end else if (accept) begin
            counter      <= '0;
            rem_acc      <= '0;
            quo_acc      <= a_mag;
            div_mag      <= b_mag;
            dividend_raw <= a;
            neg_q        <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r        <= is_signed && a[WIDTH-1];
            div_zero     <= (b == '0);
        end else if (state == BUSY && !cancel) begin
            counter <= counter + 1'b1;
            rem_acc <= rem_step;
            quo_acc <= quo_step;
            if (last_iter) begin
                if (div_zero) begin
                    // Divide by zero reports all-ones and the raw dividend, with no sign fix-up.
                    quotient  <= {WIDTH{1'b1}};
                    remainder <= dividend_raw;
                end else begin
                    // The remainder follows the dividend's sign. The most-negative / -1
                    // case wraps back to the most-negative value by itself.
                    quotient  <= neg_q ? (~quo_step + 1'b1) : quo_step;
                    remainder <= neg_r ? (~rem_step + 1'b1) : rem_step;
                end
            end
        end
    end

endmodule
